regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the register file's single write port between the two writeback sources, ALU and LSU, and tracks which destination registers still have writes in flight. Each source presents a valid/ready writeback request. The block arbitrates between them and drives registered write_enable/write_addr/data_in to the register file. A 32-entry pending-write scoreboard drives the decode-stage hazard flags. It sits between the execute/memory stages and the register file.

## Interface
- MAX_WAIT, default 4: consecutive cycles the ALU may lose arbitration before it is forced to win; legal range 1..15.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU request accepted this cycle.
- lsu_valid  in  1  LSU writeback request.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  load result.
- lsu_ready  out  1  LSU request accepted this cycle.
- issue_valid  in  1  an instruction with a destination issued this cycle.
- issue_rd  in  5  destination of the issuing instruction.
- chk_addr1  in  5  decode source register 1.
- chk_addr2  in  5  decode source register 2.
- hazard1  out  1  chk_addr1 has a pending write.
- hazard2  out  1  chk_addr2 has a pending write.
- rf_write_enable  out  1  register file write strobe; registered.
- rf_write_addr  out  5  register file write address; registered.
- rf_data_in  out  32  register file write data; registered.

## Operation
- A transfer occurs on a port when valid && ready at a posedge.
- Arbitration is combinational from alu_valid, lsu_valid and the wait counter. ready never depends on ready.
  - Only one valid: that port gets ready=1.
  - Both valid: LSU wins by default. The ALU wins only when the wait counter equals MAX_WAIT (guard build only).
  - Neither valid: both ready=0.
- Wait counter (guard build only), width 4 bits:
  - Increments when alu_valid && !alu_ready.
  - Clears on an ALU transfer or when alu_valid=0.
  - Saturates at MAX_WAIT.
- Write register update at each posedge:
  - On a transfer: rf_write_addr and rf_data_in load the winner's rd and data; rf_write_enable = (rd != 0).
  - With no transfer: rf_write_enable = 0, and addr/data hold their previous values.
  - Writes to rd=0 are accepted (ready=1) and dropped.
- Scoreboard pend[31:0]:
  - issue_valid with issue_rd != 0 sets pend[issue_rd].
  - A transfer with rd != 0 clears pend[rd].
  - The same register set and cleared at the same edge: set wins, because a newer writer is in flight.
  - pend[0] is constant 0.
- hazard1 = pend[chk_addr1]; hazard2 = pend[chk_addr2]. Both are combinational from the registered pend.

## Timing
- Reset values: rf_write_enable=0, rf_write_addr=0, rf_data_in=0, pend=0, wait counter=0.
- While rst_n=0 all outputs stay at reset values; ready outputs are forced to 0.
- Writeback latency:
  - A transfer at edge N gives rf_write_enable=1 during cycle N..N+1.
  - The register file captures the write at edge N+1.
  - pend clears at edge N, so the hazard drops one cycle before the write lands. Decode stalls for one more cycle or uses bypass; that handling is outside this block.
- Throughput: one writeback per cycle, no bubbles between back-to-back transfers.
- The losing requester keeps valid and its payload stable until its ready; the bench checks this.
- Reset mid-operation: an in-flight registered write is discarded (rf_write_enable forced 0) and all pending bits are lost. The pipeline is flushed by the same reset.

## Configuration
- WB_STARVE_GUARD_EN defined:
  - The wait counter is instantiated.
  - With both sources continuously valid, the ALU wins at least once every MAX_WAIT+1 cycles.
- WB_STARVE_GUARD_EN undefined:
  - Strict LSU priority; no counter; MAX_WAIT is ignored.
  - The ALU can starve indefinitely while lsu_valid stays high.

## Structure
- Shared package regfile_pkg holds:
  - REG_ADDR_W=5 and XLEN=32.
  - typedef wb_req_t {rd[4:0], data[31:0]}.
  - REG_ZERO=5'd0.
- Sub-module regfile_scoreboard: the pend register, the set/clear logic with set priority, and the two hazard lookups. Its ports are clk, rst_n, set_valid/set_rd, clr_valid/clr_rd, chk_addr1/2 and hazard1/2.
- The arbiter and the write register stay in the top module.

## Test plan
- ALU-only write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle.
  - Expect alu_ready=1 that cycle.
  - Next cycle: rf_write_enable=1, rf_write_addr=5, rf_data_in=0xDEADBEEF.
  - The cycle after: rf_write_enable=0.
- Contention: both sources valid, ALU rd=1, LSU rd=2.
  - Expect lsu_ready=1 and alu_ready=0.
  - The write to 2 precedes the write to 1.
  - The ALU is granted the cycle after lsu_valid drops.
- Starvation guard (guard build, MAX_WAIT=4): LSU valid continuously, ALU valid continuously.
  - Expect the ALU granted on the 5th cycle, then LSU resumes.
  - In the non-guard build the ALU is never granted while the LSU is valid.
- x0 drop: lsu_rd=0, lsu_data=0x1234 with issue_rd=0.
  - Expect lsu_ready=1, rf_write_enable stays 0, pend stays 0.
  - chk_addr1=0 gives hazard1=0.
- Scoreboard:
  - issue rd=7 gives hazard1=1 for chk_addr1=7.
  - An ALU writeback to 7 in the same cycle as a new issue to 7 leaves pend[7]=1.
  - A later writeback to 7 with no issue clears it, giving hazard1=0.
- Async reset mid-transfer: assert rst_n=0 between edges with a transfer registered.
  - Expect rf_write_enable=0 immediately, all ready=0, pend=0.
  - After release, a fresh request is granted normally.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and the writeback request type for the register-file
// writeback path.
package regfile_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue,
// cleared at writeback, looked up by decode for hazard detection.
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_valid,
   input  logic [REG_ADDR_W-1:0] set_rd,
   input  logic                  clr_valid,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   input  logic [REG_ADDR_W-1:0] chk_addr1,
   input  logic [REG_ADDR_W-1:0] chk_addr2,
   output logic                  hazard1,
   output logic                  hazard2
);
   logic [NUM_REGS-1:0] r_pend;
   logic [NUM_REGS-1:0] w_set;
   logic [NUM_REGS-1:0] w_clr;

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (set_valid) w_set[set_rd] = 1'b1;
      if (clr_valid) w_clr[clr_rd] = 1'b1;
   end

   // Set is applied after clear so a same-edge reissue keeps the bit; x0 never pends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_pend <= '0;
      else        r_pend <= ((r_pend & ~w_clr) | w_set) & ~NUM_REGS'(1);
   end

   assign hazard1 = r_pend[chk_addr1];
   assign hazard2 = r_pend[chk_addr2];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/LSU writebacks onto the single register-file write port and
// tracks pending destinations. Define WB_STARVE_GUARD_EN for the ALU wait counter.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [REG_ADDR_W-1:0] lsu_rd,
   input  logic [XLEN-1:0]       lsu_data,
   output logic                  lsu_ready,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic [REG_ADDR_W-1:0] chk_addr1,
   input  logic [REG_ADDR_W-1:0] chk_addr2,
   output logic                  hazard1,
   output logic                  hazard2,
   output logic                  rf_write_enable,
   output logic [REG_ADDR_W-1:0] rf_write_addr,
   output logic [XLEN-1:0]       rf_data_in
);
   logic    w_force_alu;
   logic    w_alu_grant;
   logic    w_lsu_grant;
   logic    w_alu_xfer;
   logic    w_xfer;
   wb_req_t w_win;

   logic                  r_we;
   logic [REG_ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]       r_data;

`ifdef WB_STARVE_GUARD_EN
   logic [3:0] r_wait;

   assign w_force_alu = (r_wait == 4'(MAX_WAIT));

   // Counts consecutive ALU losses; saturates so the forced win repeats if needed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                       r_wait <= '0;
      else if (!alu_valid || w_alu_xfer) r_wait <= '0;
      else if (!w_force_alu)            r_wait <= r_wait + 4'd1;
   end
`else
   logic w_unused_max_wait;

   assign w_force_alu       = 1'b0;
   assign w_unused_max_wait = (MAX_WAIT != 0);
`endif

   assign w_alu_grant = alu_valid && (!lsu_valid || w_force_alu);
   assign w_lsu_grant = lsu_valid && !w_alu_grant;

   assign alu_ready  = rst_n && w_alu_grant;
   assign lsu_ready  = rst_n && w_lsu_grant;
   assign w_alu_xfer = alu_ready;
   assign w_xfer     = alu_ready || lsu_ready;

   always_comb begin
      w_win = '{rd: lsu_rd, data: lsu_data};
      if (w_alu_xfer) w_win = '{rd: alu_rd, data: alu_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_we   <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (w_xfer) begin
         r_we   <= (w_win.rd != REG_ZERO);
         r_addr <= w_win.rd;
         r_data <= w_win.data;
      end else begin
         r_we   <= 1'b0;
      end
   end

   assign rf_write_enable = r_we;
   assign rf_write_addr   = r_addr;
   assign rf_data_in      = r_data;

   regfile_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_valid (issue_valid),
      .set_rd    (issue_rd),
      .clr_valid (w_xfer),
      .clr_rd    (w_win.rd),
      .chk_addr1 (chk_addr1),
      .chk_addr2 (chk_addr2),
      .hazard1   (hazard1),
      .hazard2   (hazard2)
   );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter; expected register-file writes are
// queued as stimulus is driven and compared one cycle later.
module tb_regfile_wb_arbiter;
   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
   logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0, chk_addr1 = '0, chk_addr2 = '0;
   logic [31:0] alu_data = '0, lsu_data = '0;
   logic        alu_ready, lsu_ready, hazard1, hazard2;
   logic        rf_write_enable;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_data_in;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          failures = 0;
   logic [4:0]  m_addr = '0;
   logic [31:0] m_data = '0;
   int          m_wait = 0;

   regfile_wb_arbiter #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .hazard1(hazard1), .hazard2(hazard2),
      .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr), .rf_data_in(rf_data_in)
   );

   always #5 clk = ~clk;

   // Consumer: each queued entry is the register-file state expected after the next edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (rf_write_enable !== e.we || rf_write_addr !== e.addr || rf_data_in !== e.data) begin
            failures++;
            $display("FAIL rf_write: got we=%0b addr=%0d data=%h, want we=%0b addr=%0d data=%h",
                     rf_write_enable, rf_write_addr, rf_data_in, e.we, e.addr, e.data);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_xfer(input logic [4:0] rd, input logic [31:0] d);
      exp_t e;
      e.we = (rd != 5'd0);
      e.addr = rd;
      e.data = d;
      m_addr = rd;
      m_data = d;
      q.push_back(e);
   endtask

   task automatic push_idle();
      exp_t e;
      e.we = 1'b0;
      e.addr = m_addr;
      e.data = m_data;
      q.push_back(e);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1 alu_valid = 1'b1;
      lsu_valid = 1'b1;
      #1;
      checks++;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: got alu=%0b lsu=%0b, want 0 0", alu_ready, lsu_ready);
      end
      checks++;
      if (rf_write_enable !== 1'b0 || rf_write_addr !== 5'd0 || rf_data_in !== 32'd0 || hazard1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: got we=%0b addr=%0d data=%h hz=%0b, want 0 0 0 0",
                  rf_write_enable, rf_write_addr, rf_data_in, hazard1);
      end
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_alu_only();
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1;
      checks++;
      if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
         failures++;
         $display("FAIL alu_only_ready: got alu=%0b lsu=%0b, want 1 0", alu_ready, lsu_ready);
      end
      push_xfer(5'd5, 32'hDEADBEEF);
      cyc();
      alu_valid = 1'b0;
      #1;
      checks++;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready: got alu=%0b lsu=%0b, want 0 0", alu_ready, lsu_ready);
      end
      push_idle();
      cyc();
   endtask

   task automatic test_contention();
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1A1A1A1;
      lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'hB2B2B2B2;
      #1;
      checks++;
      if (lsu_ready !== 1'b1 || alu_ready !== 1'b0) begin
         failures++;
         $display("FAIL contention_lsu_wins: got alu=%0b lsu=%0b, want 0 1", alu_ready, lsu_ready);
      end
      push_xfer(5'd2, 32'hB2B2B2B2);
      cyc();
      lsu_valid = 1'b0;
      #1;
      checks++;
      if (alu_ready !== 1'b1 || lsu_ready !== 1'b0) begin
         failures++;
         $display("FAIL contention_alu_next: got alu=%0b lsu=%0b, want 1 0", alu_ready, lsu_ready);
      end
      push_xfer(5'd1, 32'hA1A1A1A1);
      cyc();
      alu_valid = 1'b0;
      #1 push_idle();
      cyc();
   endtask

   task automatic test_x0_drop();
      lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234;
      issue_valid = 1'b1; issue_rd = 5'd0; chk_addr1 = 5'd0;
      #1;
      checks++;
      if (lsu_ready !== 1'b1 || hazard1 !== 1'b0) begin
         failures++;
         $display("FAIL x0_accept: got ready=%0b hz=%0b, want 1 0", lsu_ready, hazard1);
      end
      push_xfer(5'd0, 32'h1234);
      cyc();
      lsu_valid = 1'b0;
      issue_valid = 1'b0;
      // Inputs idle, so the scan may span edges without changing state.
      for (int r = 0; r < 32; r++) begin
         chk_addr1 = 5'(r);
         chk_addr2 = 5'(31 - r);
         #1;
         checks++;
         if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
            failures++;
            $display("FAIL x0_pend_clear: reg %0d got hz1=%0b hz2=%0b, want 0 0", r, hazard1, hazard2);
         end
      end
      cyc();
   endtask

   task automatic test_scoreboard();
      issue_valid = 1'b1; issue_rd = 5'd7; chk_addr1 = 5'd7; chk_addr2 = 5'd8;
      #1;
      checks++;
      if (hazard1 !== 1'b0) begin
         failures++;
         $display("FAIL sb_before_set: got hz1=%0b, want 0", hazard1);
      end
      push_idle();
      cyc();
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      #1;
      checks++;
      if (hazard1 !== 1'b1 || hazard2 !== 1'b0 || alu_ready !== 1'b1) begin
         failures++;
         $display("FAIL sb_set: got hz1=%0b hz2=%0b rdy=%0b, want 1 0 1", hazard1, hazard2, alu_ready);
      end
      push_xfer(5'd7, 32'h77);
      cyc();
      alu_valid = 1'b0;
      issue_valid = 1'b0;
      #1;
      checks++;
      if (hazard1 !== 1'b1) begin
         failures++;
         $display("FAIL sb_set_wins: got hz1=%0b, want 1", hazard1);
      end
      push_idle();
      cyc();
      alu_valid = 1'b1; alu_data = 32'h78;
      #1 push_xfer(5'd7, 32'h78);
      cyc();
      alu_valid = 1'b0;
      #1;
      checks++;
      if (hazard1 !== 1'b0) begin
         failures++;
         $display("FAIL sb_clear: got hz1=%0b, want 0", hazard1);
      end
      push_idle();
      cyc();
   endtask

   task automatic test_starve();
      int   lsu_n;
      logic exp_alu;
      lsu_n = 0;
      m_wait = 0;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hC3C3C3C3;
      for (int i = 0; i < 12; i++) begin
         lsu_valid = 1'b1;
         lsu_rd = 5'(10 + lsu_n);
         lsu_data = 32'hB00 + 32'(lsu_n);
         #1;
`ifdef WB_STARVE_GUARD_EN
         exp_alu = (m_wait == MW);
`else
         exp_alu = 1'b0;
`endif
         checks++;
         if (alu_ready !== exp_alu || lsu_ready !== !exp_alu) begin
            failures++;
            $display("FAIL starve_cycle%0d: got alu=%0b lsu=%0b, want %0b %0b",
                     i, alu_ready, lsu_ready, exp_alu, !exp_alu);
         end
         if (exp_alu) begin
            push_xfer(5'd3, 32'hC3C3C3C3);
            m_wait = 0;
         end else begin
            push_xfer(lsu_rd, lsu_data);
            lsu_n++;
            if (m_wait < MW) m_wait++;
         end
         cyc();
      end
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      m_wait = 0;
      #1 push_idle();
      cyc();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         lsu_valid = 1'b1;
         lsu_rd = 5'(11 + i);
         lsu_data = $urandom;
         #1;
         checks++;
         if (lsu_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready%0d: got %0b, want 1", i, lsu_ready);
         end
         push_xfer(lsu_rd, lsu_data);
         cyc();
      end
      lsu_valid = 1'b0;
      #1 push_idle();
      cyc();
   endtask

   task automatic test_reset_mid();
      issue_valid = 1'b1; issue_rd = 5'd9;
      alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
      #1 push_xfer(5'd20, 32'h2020);
      cyc();
      issue_valid = 1'b0;
      alu_rd = 5'd21; alu_data = 32'h2121;
      chk_addr1 = 5'd9; chk_addr2 = 5'd20;
      #2;
      checks++;
      if (hazard1 !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_pre: got hz1=%0b, want 1", hazard1);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rf_write_enable !== 1'b0 || rf_write_addr !== 5'd0 || rf_data_in !== 32'd0) begin
         failures++;
         $display("FAIL rst_mid_wr: got we=%0b addr=%0d data=%h, want 0 0 0",
                  rf_write_enable, rf_write_addr, rf_data_in);
      end
      checks++;
      if (alu_ready !== 1'b0 || lsu_ready !== 1'b0 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid_flush: got alu=%0b lsu=%0b hz1=%0b hz2=%0b, want 0 0 0 0",
                  alu_ready, lsu_ready, hazard1, hazard2);
      end
      alu_valid = 1'b0;
      m_addr = '0;
      m_data = '0;
      m_wait = 0;
      cyc();
      rst_n = 1'b1;
      alu_valid = 1'b1; alu_rd = 5'd22; alu_data = 32'h2222;
      #1;
      checks++;
      if (alu_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_after: got alu_ready=%0b, want 1", alu_ready);
      end
      push_xfer(5'd22, 32'h2222);
      cyc();
      alu_valid = 1'b0;
      #1 push_idle();
      cyc();
   endtask

   initial begin
      test_reset();
      test_alu_only();
      test_contention();
      test_x0_drop();
      test_scoreboard();
      test_starve();
      test_back_to_back();
      test_reset_mid();
      cyc();
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: %0d entries left, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
